// File: rtl/lane_rr_serializer_pkg.sv
// Shared constants and the round-robin pointer type for the four-lane byte serializer.
package lane_rr_serializer_pkg;

   localparam int DATA_W     = 8;
   localparam int FIFO_DEPTH = 4;
   localparam int AFULL_THR  = 3;
   localparam int NUM_LANES  = 4;
   localparam int LANE_W     = 2;
   localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

   typedef enum logic [LANE_W-1:0] {
      L0 = 2'd0,
      L1 = 2'd1,
      L2 = 2'd2,
      L3 = 2'd3
   } rr_state_t;

   // Pointer moves to the lane just after the one that was served.
   function automatic rr_state_t rr_after(input logic [LANE_W-1:0] lane);
      return rr_state_t'(lane + 2'd1);
   endfunction

endpackage

// File: rtl/lane_rr_serializer_byte_fifo.sv
// Per-lane byte FIFO with a combinational head; a full FIFO still takes a push when popped on the same edge.
module byte_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    reset_L,
   input  logic                    push,
   input  logic                    pop,
   input  logic [WIDTH-1:0]        din,
   output logic [WIDTH-1:0]        head,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    full,
   output logic                    empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W:0]   count_reg;
   logic [PTR_W:0]   count_next;
   logic             do_pop;
   logic             do_push;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == (PTR_W+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr_reg];
   assign count   = count_reg;

   always_comb begin
      count_next = count_reg;
      if (do_push && !do_pop) begin
         count_next = count_reg + 1'b1;
      end else if (do_pop && !do_push) begin
         count_next = count_reg - 1'b1;
      end
   end

   // Storage carries no reset; only the pointers and count define occupancy.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= din;
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         count_reg <= count_next;
      end
   end

endmodule

// File: rtl/lane_rr_serializer.sv
// Four lane FIFOs merged into one registered byte stream by a round-robin arbiter.
module lane_rr_serializer
   import lane_rr_serializer_pkg::*;
(
   input  logic              clk,
   input  logic              reset_L,
   input  logic [DATA_W-1:0] data_in0,
   input  logic [DATA_W-1:0] data_in1,
   input  logic [DATA_W-1:0] data_in2,
   input  logic [DATA_W-1:0] data_in3,
   input  logic              valid_in0,
   input  logic              valid_in1,
   input  logic              valid_in2,
   input  logic              valid_in3,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic [LANE_W-1:0] lane_out,
   output logic              pause_out,
   output logic              overflow_err
);

   logic [DATA_W-1:0]    lane_data [NUM_LANES];
   logic [DATA_W-1:0]    head [NUM_LANES];
   logic [CNT_W-1:0]     count [NUM_LANES];
   logic [CNT_W-1:0]     count_post [NUM_LANES];
   logic [NUM_LANES-1:0] lane_valid;
   logic [NUM_LANES-1:0] full;
   logic [NUM_LANES-1:0] empty;
   logic [NUM_LANES-1:0] pop;
   logic [NUM_LANES-1:0] accept;
   logic [NUM_LANES-1:0] drop;
   logic [NUM_LANES-1:0] afull;
   rr_state_t            rr_reg;
   logic                 grant_found;
   logic [LANE_W-1:0]    grant_lane;
   logic [LANE_W-1:0]    cand;

   assign lane_data[0] = data_in0;
   assign lane_data[1] = data_in1;
   assign lane_data[2] = data_in2;
   assign lane_data[3] = data_in3;
   assign lane_valid   = {valid_in3, valid_in2, valid_in1, valid_in0};

   // First non-empty lane at or after rr_reg, judged on pre-push occupancy.
   always_comb begin
      grant_found = 1'b0;
      grant_lane  = '0;
      cand        = '0;
      for (int off = 0; off < NUM_LANES; off++) begin
         cand = rr_reg + LANE_W'(off);
         if (!grant_found && !empty[cand]) begin
            grant_found = 1'b1;
            grant_lane  = cand;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
         assign pop[gi]        = grant_found && (grant_lane == LANE_W'(gi));
         assign accept[gi]     = lane_valid[gi] && (!full[gi] || pop[gi]);
         assign drop[gi]       = lane_valid[gi] && full[gi] && !pop[gi];
         assign count_post[gi] = count[gi] + CNT_W'(accept[gi]) - CNT_W'(pop[gi]);
         assign afull[gi]      = (count_post[gi] >= CNT_W'(AFULL_THR));

         byte_fifo #(
            .WIDTH (DATA_W),
            .DEPTH (FIFO_DEPTH)
         ) u_fifo (
            .clk     (clk),
            .reset_L (reset_L),
            .push    (accept[gi]),
            .pop     (pop[gi]),
            .din     (lane_data[gi]),
            .head    (head[gi]),
            .count   (count[gi]),
            .full    (full[gi]),
            .empty   (empty[gi])
         );
      end
   endgenerate

   // When nothing is granted the last byte and lane index stay on the bus.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         rr_reg       <= L0;
         data_out     <= '0;
         valid_out    <= 1'b0;
         lane_out     <= '0;
         pause_out    <= 1'b0;
         overflow_err <= 1'b0;
      end else begin
         valid_out <= grant_found;
         if (grant_found) begin
            data_out <= head[grant_lane];
            lane_out <= grant_lane;
            rr_reg   <= rr_after(grant_lane);
         end
         pause_out <= |afull;
         if (|drop) begin
            overflow_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_lane_rr_serializer.sv
// Randomised and directed checks of lane_rr_serializer against a queue-based lane model.
module tb_lane_rr_serializer;

   localparam int DEPTH = 4;
   localparam int THR   = 3;

   logic       clk = 1'b0;
   logic       reset_L;
   logic [7:0] data_in0, data_in1, data_in2, data_in3;
   logic       valid_in0, valid_in1, valid_in2, valid_in3;
   logic [7:0] data_out;
   logic       valid_out;
   logic [1:0] lane_out;
   logic       pause_out;
   logic       overflow_err;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] m_q [4][$];
   int         m_rr;
   logic       m_valid;
   logic [1:0] m_lane;
   logic [7:0] m_data;
   logic       m_pause;
   logic       m_ovf;

   always #5 clk = ~clk;

   lane_rr_serializer dut (
      .clk          (clk),
      .reset_L      (reset_L),
      .data_in0     (data_in0),
      .data_in1     (data_in1),
      .data_in2     (data_in2),
      .data_in3     (data_in3),
      .valid_in0    (valid_in0),
      .valid_in1    (valid_in1),
      .valid_in2    (valid_in2),
      .valid_in3    (valid_in3),
      .data_out     (data_out),
      .valid_out    (valid_out),
      .lane_out     (lane_out),
      .pause_out    (pause_out),
      .overflow_err (overflow_err)
   );

   function automatic logic [12:0] obs();
      return {valid_out, lane_out, data_out, pause_out, overflow_err};
   endfunction

   function automatic logic [12:0] expv();
      return {m_valid, m_lane, m_data, m_pause, m_ovf};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_q[i].delete();
      m_rr = 0; m_valid = 1'b0; m_lane = 2'd0; m_data = 8'h00;
      m_pause = 1'b0; m_ovf = 1'b0;
   endtask

   task automatic drive_idle();
      {valid_in3, valid_in2, valid_in1, valid_in0} = 4'b0000;
      {data_in3, data_in2, data_in1, data_in0} = 32'h0;
   endtask

   // Drive one cycle of lane inputs, advance the lane model, and wait past the edge.
   task automatic cycle(input logic [3:0] v, input logic [3:0][7:0] d);
      bit found;
      int k;
      {valid_in3, valid_in2, valid_in1, valid_in0} = v;
      data_in0 = d[0]; data_in1 = d[1]; data_in2 = d[2]; data_in3 = d[3];
      found = 1'b0;
      k = 0;
      for (int off = 0; off < 4; off++) begin
         int l;
         l = (m_rr + off) % 4;
         if (!found && m_q[l].size() != 0) begin
            found = 1'b1;
            k = l;
         end
      end
      m_valid = found;
      if (found) begin
         m_data = m_q[k].pop_front();
         m_lane = 2'(k);
         m_rr   = (k + 1) % 4;
      end
      for (int i = 0; i < 4; i++) begin
         if (v[i]) begin
            if (m_q[i].size() < DEPTH) m_q[i].push_back(d[i]);
            else m_ovf = 1'b1;
         end
      end
      m_pause = 1'b0;
      for (int i = 0; i < 4; i++) if (m_q[i].size() >= THR) m_pause = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive_idle();
      reset_L = 1'b0;
      #2;
      reset_L = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      logic [3:0][7:0] d;
      drive_idle();
      reset_L = 1'b0;
      model_reset();
      #1;
      n_cmp++;
      if (obs() !== 13'h0) begin
         n_bad++;
         $display("FAIL reset_init got {v,lane,data,pause,ovf}=%b want %b", obs(), 13'h0);
      end
      #20;
      reset_L = 1'b1;
      @(posedge clk);
      #1;
      for (int c = 0; c < 3; c++) begin
         for (int i = 0; i < 4; i++) d[i] = 8'h80 | 8'($urandom_range(0, 127));
         cycle(4'b1111, d);
         n_cmp++;
         if (obs() !== expv()) begin
            n_bad++;
            $display("FAIL reset_stream cyc%0d got %b want %b", c, obs(), expv());
         end
      end
      #2;
      reset_L = 1'b0;
      model_reset();
      #1;
      n_cmp++;
      if (obs() !== 13'h0) begin
         n_bad++;
         $display("FAIL reset_async got %b want %b", obs(), 13'h0);
      end
      drive_idle();
      @(posedge clk);
      #3;
      reset_L = 1'b1;
      for (int c = 0; c < 3; c++) begin
         cycle(4'b0000, '0);
         n_cmp++;
         if (obs() !== expv() || valid_out !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release cyc%0d got %b want %b", c, obs(), expv());
         end
      end
   endtask

   task automatic test_single_lane();
      logic [3:0][7:0] d;
      logic            want_v;
      for (int c = 0; c < 6; c++) begin
         d = '0;
         d[2] = 8'(8'hA1 + c);
         cycle((c < 3) ? 4'b0100 : 4'b0000, d);
         n_cmp++;
         if (obs() !== expv()) begin
            n_bad++;
            $display("FAIL single_lane_model cyc%0d got %b want %b", c, obs(), expv());
         end
         want_v = (c >= 1 && c <= 3);
         n_cmp++;
         if (valid_out !== want_v ||
             (want_v && {lane_out, data_out} !== {2'd2, 8'(8'hA0 + c)})) begin
            n_bad++;
            $display("FAIL single_lane cyc%0d got v=%b lane=%0d data=%h want v=%b lane=2 data=%h",
                     c, valid_out, lane_out, data_out, want_v, 8'(8'hA0 + c));
         end
      end
   endtask

   task automatic test_round_robin();
      logic [3:0][7:0] d;
      do_reset();
      d = {8'h13, 8'h12, 8'h11, 8'h10};
      for (int c = 0; c < 6; c++) begin
         cycle((c == 0) ? 4'b1111 : 4'b0000, d);
         n_cmp++;
         if (obs() !== expv()) begin
            n_bad++;
            $display("FAIL round_robin_model cyc%0d got %b want %b", c, obs(), expv());
         end
         if (c >= 1) begin
            n_cmp++;
            if ((c <= 4 && {valid_out, lane_out, data_out} !== {1'b1, 2'(c - 1), 8'(8'h0F + c)}) ||
                (c == 5 && valid_out !== 1'b0)) begin
               n_bad++;
               $display("FAIL round_robin cyc%0d got v=%b lane=%0d data=%h", c, valid_out, lane_out, data_out);
            end
         end
      end
   endtask

   task automatic test_skip_empty();
      logic [3:0]      v_tab [7] = '{4'b0001, 4'b1001, 4'b0000, 4'b0000, 4'b0011, 4'b0000, 4'b0000};
      int              lane_tab [7] = '{-1, 0, 3, 0, -1, 1, 0};
      logic [3:0][7:0] d;
      do_reset();
      for (int c = 0; c < 7; c++) begin
         d = {8'h23, 8'h00, 8'h31, 8'(c < 4 ? 8'h20 + c : 8'h30)};
         cycle(v_tab[c], d);
         n_cmp++;
         if (obs() !== expv()) begin
            n_bad++;
            $display("FAIL skip_empty_model cyc%0d got %b want %b", c, obs(), expv());
         end
         n_cmp++;
         if ((lane_tab[c] < 0 && valid_out !== 1'b0) ||
             (lane_tab[c] >= 0 && {valid_out, lane_out} !== {1'b1, 2'(lane_tab[c])})) begin
            n_bad++;
            $display("FAIL skip_empty cyc%0d got v=%b lane=%0d want lane %0d", c, valid_out, lane_out, lane_tab[c]);
         end
      end
   endtask

   task automatic test_pause_overflow();
      logic [3:0][7:0] d;
      do_reset();
      for (int c = 0; c < 14; c++) begin
         for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
         cycle((c < 6) ? 4'b1111 : 4'b0000, d);
         n_cmp++;
         if (obs() !== expv()) begin
            n_bad++;
            $display("FAIL pause_overflow_model cyc%0d got %b want %b", c, obs(), expv());
         end
         if (c == 1 || c == 2) begin
            n_cmp++;
            if (pause_out !== (c == 2)) begin
               n_bad++;
               $display("FAIL pause_rise cyc%0d got pause=%b want %b", c, pause_out, (c == 2));
            end
         end
      end
      n_cmp++;
      if (overflow_err !== 1'b1) begin
         n_bad++;
         $display("FAIL overflow_sticky got %b want 1", overflow_err);
      end
   endtask

   task automatic test_full_pop_same();
      logic [3:0][7:0] d;
      int              n_out;
      do_reset();
      n_out = 0;
      for (int c = 0; c < 12; c++) begin
         d = {8'hD3, 8'hD2, 8'hD1, 8'(8'hC0 + c)};
         cycle((c == 0) ? 4'b1111 : (c <= 5) ? 4'b0001 : 4'b0000, d);
         n_cmp++;
         if (obs() !== expv()) begin
            n_bad++;
            $display("FAIL full_pop_model cyc%0d got %b want %b", c, obs(), expv());
         end
         if (c == 5) begin
            n_cmp++;
            if ({overflow_err, pause_out} !== 2'b01) begin
               n_bad++;
               $display("FAIL full_pop_push got ovf=%b pause=%b want ovf=0 pause=1", overflow_err, pause_out);
            end
         end
         if (c >= 6 && valid_out) n_out++;
      end
      n_cmp++;
      if (n_out != 4) begin
         n_bad++;
         $display("FAIL full_pop_drain got %0d bytes want 4", n_out);
      end
   endtask

   task automatic test_random();
      logic [3:0][7:0] d;
      logic [3:0]      v;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 4; i++) begin
            d[i] = 8'($urandom);
            v[i] = ($urandom_range(0, 2) == 0);
         end
         if (pause_out && $urandom_range(0, 9) != 0) v = 4'b0000;
         cycle(v, d);
         n_cmp++;
         if (obs() !== expv()) begin
            n_bad++;
            $display("FAIL random cyc%0d got %b want %b", c, obs(), expv());
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_lane();
      test_round_robin();
      test_skip_empty();
      test_pause_overflow();
      test_full_pop_same();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
